// File: rtl/dec_n_onehot_seq_pkg.sv
// Shared types and helpers for the dec_n_onehot_seq decoder: FSM state
// encoding, mode constants and a constant-foldable ceil(log2) helper.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIRECT = 2'b01,
    SCAN   = 2'b10
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_n_onehot_seq_scan_ctr.sv
// Scan sequencer: dwell counter plus wrap-around index counter. idx/wrap are
// the values for the coming cycle, so the parent can register them directly.
module dec_scan_ctr
  import dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam int CNT_W = clog2(DWELL) + 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Anything other than a continuing scan parks both counters at zero, so a
  // restart and an idle parent look identical to the sequencer.
  always_comb begin
    idx   = '0;
    cnt_d = '0;
    wrap  = 1'b0;
    if (run && !restart) begin
      if (cnt_q == LAST_CNT) begin
        if (idx_q == LAST_IDX) wrap = 1'b1;
        else                   idx  = idx_q + SEL_W'(1);
      end else begin
        idx   = idx_q;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dec_n_onehot_seq.sv
// Registered SEL_W -> NUM_OUT one-hot decoder with direct and scan modes.
// Define DEC_STICKY_ERR_EN for a sticky range_err cleared by err_clr.
module dec_n_onehot_seq
  import dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
`ifdef DEC_STICKY_ERR_EN
  input  logic               err_clr,
`endif
  output logic [NUM_OUT-1:0] dec_out,
  output logic               out_valid,
  output logic               range_err,
  output logic [SEL_W-1:0]   scan_idx,
  output logic               scan_wrap
);

  state_e           state;
  state_e           state_nxt;
  logic [SEL_W-1:0] ctr_idx;
  logic             ctr_wrap;
  logic             scan_run;
  logic             scan_restart;
  logic             sel_in_range;
  logic             err_set;

  function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [NUM_OUT-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_OUT; k++) oh[k] = (int'(i) == k);
    return oh;
  endfunction

  always_comb begin
    state_nxt = IDLE;
    if (enable) state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
  end

  assign scan_run     = (state_nxt == SCAN) && (state == SCAN);
  assign scan_restart = (state_nxt == SCAN) && (state != SCAN);
  assign sel_in_range = int'(sel) < NUM_OUT;
  assign err_set      = (state_nxt == DIRECT) && sel_valid && !sel_in_range;

  dec_scan_ctr #(
    .SEL_W  (SEL_W),
    .NUM_OUT(NUM_OUT),
    .DWELL  (DWELL)
  ) u_scan_ctr (
    .clk    (clk),
    .rst    (rst),
    .run    (scan_run),
    .restart(scan_restart),
    .idx    (ctr_idx),
    .wrap   (ctr_wrap)
  );

  // Outputs follow the state being entered, so a mode change takes effect
  // on the same edge that samples it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dec_out   <= '0;
      out_valid <= 1'b0;
      scan_idx  <= '0;
      scan_wrap <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state_nxt)
        DIRECT: begin
          scan_idx  <= '0;
          scan_wrap <= 1'b0;
          if (sel_valid) begin
            dec_out   <= sel_in_range ? onehot(sel) : '0;
            out_valid <= sel_in_range;
          end
        end
        SCAN: begin
          dec_out   <= onehot(ctr_idx);
          out_valid <= 1'b1;
          scan_idx  <= ctr_idx;
          scan_wrap <= ctr_wrap;
        end
        default: begin
          dec_out   <= '0;
          out_valid <= 1'b0;
          scan_idx  <= '0;
          scan_wrap <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEC_STICKY_ERR_EN
  // A new error in the same cycle as err_clr must not be lost.
  always_ff @(posedge clk) begin
    if (rst) range_err <= 1'b0;
    else     range_err <= err_set | (range_err & ~err_clr);
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if (state_nxt == DIRECT) begin
      if (sel_valid) range_err <= err_set;
    end else begin
      range_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dec_n_onehot_seq.sv
// Self-checking bench for dec_n_onehot_seq (SEL_W=3, NUM_OUT=6, DWELL=2).
module tb_dec_n_onehot_seq;

  localparam int SEL_W   = 3;
  localparam int NUM_OUT = 6;
  localparam int DWELL   = 2;
`ifdef DEC_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst, enable, mode, sel_valid, err_clr;
  logic [SEL_W-1:0]   sel;
  logic [NUM_OUT-1:0] dec_out;
  logic               out_valid, range_err, scan_wrap;
  logic [SEL_W-1:0]   scan_idx;

  always #5 clk = ~clk;

  dec_n_onehot_seq #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT), .DWELL(DWELL)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .mode     (mode),
    .sel      (sel),
    .sel_valid(sel_valid),
`ifdef DEC_STICKY_ERR_EN
    .err_clr  (err_clr),
`endif
    .dec_out  (dec_out),
    .out_valid(out_valid),
    .range_err(range_err),
    .scan_idx (scan_idx),
    .scan_wrap(scan_wrap)
  );

  typedef struct packed {
    logic [NUM_OUT-1:0] dec;
    logic               v;
    logic               err;
    logic [SEL_W-1:0]   idx;
    logic               wrap;
    logic               chk_idx;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic [NUM_OUT-1:0] d, input logic v, input logic err,
                              input logic [SEL_W-1:0] idx, input logic wrap, input logic chk);
    exp_t e;
    e.dec = d; e.v = v; e.err = err; e.idx = idx; e.wrap = wrap; e.chk_idx = chk;
    return e;
  endfunction

  // scan_idx is only meaningful while scanning or idle; elsewhere it is taken from e.
  function automatic exp_t sample(input exp_t e);
    exp_t o;
    o = mk(dec_out, out_valid, range_err, e.chk_idx ? scan_idx : e.idx, scan_wrap, e.chk_idx);
    return o;
  endfunction

  function automatic exp_t scan_exp(input int k);
    int idx;
    idx = (k / DWELL) % NUM_OUT;
    return mk(NUM_OUT'(1) << idx, 1'b1, 1'b0, SEL_W'(idx),
              (k > 0) && (k % (DWELL * NUM_OUT) == 0), 1'b1);
  endfunction

  task automatic drive(input logic r, input logic en, input logic md,
                       input logic [SEL_W-1:0] s, input logic sv, input logic clr);
    rst = r; enable = en; mode = md; sel = s; sel_valid = sv; err_clr = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e, o;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
      sb.push_back(mk('0, 1'b0, 1'b0, '0, 1'b0, 1'b1));
      tick();
      e = sb.pop_front(); o = sample(e); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d] got dec=%b v=%b err=%b idx=%0d wrap=%b want dec=%b v=%b err=%b idx=%0d wrap=%b",
                 c, o.dec, o.v, o.err, o.idx, o.wrap, e.dec, e.v, e.err, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_direct_sweep;
    exp_t e, o;
    for (int i = 0; i < NUM_OUT; i++) begin
      drive(1'b0, 1'b1, 1'b0, SEL_W'(i), 1'b1, 1'b0);
      sb.push_back(mk(NUM_OUT'(1) << i, 1'b1, 1'b0, '0, 1'b0, 1'b0));
      tick();
      e = sb.pop_front(); o = sample(e); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL direct_sweep[%0d] got dec=%b v=%b err=%b wrap=%b want dec=%b v=%b err=%b wrap=%b",
                 i, o.dec, o.v, o.err, o.wrap, e.dec, e.v, e.err, e.wrap);
      end
    end
  endtask

  task automatic test_range_hold;
    exp_t e, o;
    typedef struct packed {logic [SEL_W-1:0] s; logic sv; logic clr;} stim_t;
    stim_t st[$];
    exp_t  ex[$];
    st.push_back({3'd6, 1'b1, 1'b0}); ex.push_back(mk('0, 1'b0, 1'b1, '0, 1'b0, 1'b0));
    st.push_back({3'd7, 1'b1, 1'b0}); ex.push_back(mk('0, 1'b0, 1'b1, '0, 1'b0, 1'b0));
    for (int h = 0; h < 3; h++) begin
      st.push_back({3'($urandom_range(0, 7)), 1'b0, 1'b0});
      ex.push_back(mk('0, 1'b0, 1'b1, '0, 1'b0, 1'b0));
    end
    st.push_back({3'd2, 1'b1, 1'b0}); ex.push_back(mk(6'b000100, 1'b1, STICKY, '0, 1'b0, 1'b0));
    st.push_back({3'd2, 1'b0, 1'b1}); ex.push_back(mk(6'b000100, 1'b1, 1'b0, '0, 1'b0, 1'b0));
    // error and clear in the same cycle: the error must survive
    st.push_back({3'd6, 1'b1, 1'b1}); ex.push_back(mk('0, 1'b0, 1'b1, '0, 1'b0, 1'b0));
    st.push_back({3'd1, 1'b1, 1'b0}); ex.push_back(mk(6'b000010, 1'b1, STICKY, '0, 1'b0, 1'b0));
    st.push_back({3'd0, 1'b0, 1'b1}); ex.push_back(mk(6'b000010, 1'b1, 1'b0, '0, 1'b0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(1'b0, 1'b1, 1'b0, st[i].s, st[i].sv, st[i].clr);
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front(); o = sample(e); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL range_hold[%0d] got dec=%b v=%b err=%b wrap=%b want dec=%b v=%b err=%b wrap=%b",
                 i, o.dec, o.v, o.err, o.wrap, e.dec, e.v, e.err, e.wrap);
      end
    end
  endtask

  task automatic test_scan;
    exp_t e, o;
    int   wraps;
    wraps = 0;
    for (int k = 0; k < 14; k++) begin
      drive(1'b0, 1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
      sb.push_back(scan_exp(k));
      tick();
      e = sb.pop_front(); o = sample(e); checks++;
      if (scan_wrap === 1'b1) wraps++;
      if (o !== e) begin
        errors++;
        $display("FAIL scan[%0d] got dec=%b v=%b err=%b idx=%0d wrap=%b want dec=%b v=%b err=%b idx=%0d wrap=%b",
                 k, o.dec, o.v, o.err, o.idx, o.wrap, e.dec, e.v, e.err, e.idx, e.wrap);
      end
    end
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL scan_wrap_count got %0d want 1", wraps);
    end
  endtask

  task automatic test_disrupt;
    exp_t e, o;
    typedef struct packed {logic r; logic en; int k;} stim_t;
    stim_t st[$];
    st.push_back({1'b0, 1'b0, -1});
    for (int k = 0; k < 7; k++) st.push_back({1'b0, 1'b1, k});
    st.push_back({1'b0, 1'b0, -1});
    for (int k = 0; k < 9; k++) st.push_back({1'b0, 1'b1, k});
    st.push_back({1'b1, 1'b1, -1});
    st.push_back({1'b0, 1'b1, 0});
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i].r, st[i].en, 1'b1, 3'd0, 1'b0, 1'b0);
      sb.push_back(st[i].k < 0 ? mk('0, 1'b0, 1'b0, '0, 1'b0, 1'b1) : scan_exp(st[i].k));
      tick();
      e = sb.pop_front(); o = sample(e); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL disrupt[%0d] got dec=%b v=%b err=%b idx=%0d wrap=%b want dec=%b v=%b err=%b idx=%0d wrap=%b",
                 i, o.dec, o.v, o.err, o.idx, o.wrap, e.dec, e.v, e.err, e.idx, e.wrap);
      end
    end
  endtask

  // Enters with the scan one cycle past its restart (index 0, first dwell cycle).
  task automatic test_mode_switch;
    exp_t e, o;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        drive(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        sb.push_back(scan_exp(i + 1));
      end else if (i < 6) begin
        drive(1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
        sb.push_back(mk(6'b000100, 1'b1, 1'b0, '0, 1'b0, 1'b0));
      end else begin
        drive(1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
        sb.push_back(mk(6'b100000, 1'b1, 1'b0, '0, 1'b0, 1'b0));
      end
      tick();
      e = sb.pop_front(); o = sample(e); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mode_switch[%0d] got dec=%b v=%b err=%b idx=%0d wrap=%b want dec=%b v=%b err=%b idx=%0d wrap=%b",
                 i, o.dec, o.v, o.err, o.idx, o.wrap, e.dec, e.v, e.err, e.idx, e.wrap);
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    test_reset();
    test_direct_sweep();
    test_range_hold();
    test_scan();
    test_disrupt();
    test_mode_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t without finishing", $time);
    $fatal(1);
  end

endmodule

// File: doc/dec_n_onehot_seq.md
Name: dec_n_onehot_seq

Overview:
Parametrised, registered successor to the fixed 2:4 decoder. Decodes a SEL_W-bit select into a one-hot NUM_OUT-wide output.
- Adds an enable-gated direct mode and an autonomous scan mode, which walks the outputs with a programmable dwell.
- Adds out-of-range detection for non-power-of-two output counts.
- Sits between control logic and per-channel enables (LED/row drivers, mux strobes).

Parameters:
SEL_W, 3, select width in bits (>=1)
NUM_OUT, 8, number of one-hot outputs; 2 <= NUM_OUT <= 2**SEL_W
DWELL, 1, clock cycles each output stays active in scan mode (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
enable  input  1  global enable; 0 forces outputs off
mode  input  1  0 = direct decode, 1 = scan
sel  input  SEL_W  select value (direct mode)
sel_valid  input  1  sel is valid this cycle
dec_out  output  NUM_OUT  registered one-hot output
out_valid  output  1  dec_out holds a valid one-hot code
range_err  output  1  last valid sel was >= NUM_OUT
scan_idx  output  SEL_W  index currently driven in scan mode
scan_wrap  output  1  one-cycle pulse when scan returns to index 0

Behaviour:
- All outputs are registered. On rst=1 at a clock edge, all outputs go to 0 and the FSM goes to IDLE. This applies even mid-scan, and rst overrides every other input.
- FSM states: IDLE, DIRECT, SCAN. The state is re-evaluated every cycle:
  - enable=0 -> IDLE
  - enable=1, mode=0 -> DIRECT
  - enable=1, mode=1 -> SCAN
- IDLE: dec_out=0, out_valid=0, scan_wrap=0. range_err and scan_idx are cleared.
- DIRECT, latency 1 cycle from the sel_valid edge to dec_out:
  - sel_valid=1 and sel<NUM_OUT: dec_out=1<<sel, out_valid=1, range_err=0.
  - sel_valid=1 and sel>=NUM_OUT: dec_out=0, out_valid=0, range_err=1.
  - sel_valid=0: dec_out, out_valid and range_err all hold their previous values.
- Entering SCAN from any other state: the first SCAN cycle drives scan_idx=0, dec_out=1, out_valid=1. The dwell counter restarts at 0.
- In SCAN:
  - Each output is held for exactly DWELL cycles, then scan_idx increments.
  - At scan_idx=NUM_OUT-1, after the dwell, scan_idx wraps to 0 and scan_wrap pulses high for 1 cycle, coincident with the dec_out=1 cycle.
  - sel and sel_valid are ignored. range_err holds 0.
- Mode change, SCAN->DIRECT: dec_out holds its last scan value until the first sel_valid, and out_valid stays 1.
- enable deasserted mid-scan: outputs clear on the next edge. Re-enabling restarts the scan at index 0.
- Invariant: dec_out is always either 0 or exactly one bit set.
- Arithmetic:
  - Dwell counter width is clog2(DWELL)+1.
  - scan_idx comparisons are against NUM_OUT-1, not 2**SEL_W-1.

Optional Feature:
Macro: DEC_STICKY_ERR_EN
- Defined:
  - Extra input port err_clr (1 bit).
  - range_err becomes sticky: it is set on any out-of-range sel_valid and cleared only by rst or err_clr=1. err_clr is applied at the edge.
  - If a set and err_clr occur in the same cycle, the set wins.
  - range_err is not cleared by IDLE or by a valid in-range sel.
- Undefined: no err_clr port. range_err behaves as in Behaviour (per-decode status).

Decomposition:
- Package dec_pkg holds:
  - the state encoding typedef (IDLE=2'b00, DIRECT=2'b01, SCAN=2'b10)
  - the MODE_DIRECT/MODE_SCAN constants
  - a clog2 helper function
- One natural sub-module: dec_scan_ctr. It holds the dwell counter plus the wrap-around index counter, with inputs clk, rst, run, restart and outputs idx, wrap.
- Top level holds the FSM and the output registers.

Test Plan:
All scenarios use the instance SEL_W=3, NUM_OUT=6, DWELL=2.
1. Reset: assert rst 2 cycles with enable=1, mode=1 -> dec_out=0, out_valid=0, range_err=0, scan_idx=0, scan_wrap=0.
2. Direct sweep: enable=1, mode=0, sel_valid=1, sel=0..5 on consecutive cycles -> one cycle later dec_out=6'b000001, 000010, ..., 100000; out_valid=1 throughout.
3. Out of range, then hold:
   - sel=6 with sel_valid=1 -> dec_out=0, out_valid=0, range_err=1.
   - Then sel_valid=0 for 3 cycles -> all three outputs hold.
   - Then sel=2 -> dec_out=6'b000100, range_err=0. With DEC_STICKY_ERR_EN, range_err stays 1 until err_clr.
4. Scan: mode=1 for 14 cycles -> each index held 2 cycles, sequence 0,0,1,1,...,5,5,0,0; scan_wrap pulses exactly once, on cycle 13.
5. Mid-scan disruption:
   - enable=0 at scan_idx=3 -> outputs 0 next edge.
   - Re-enable -> scan restarts at dec_out=6'b000001.
   - rst asserted at scan_idx=4 -> identical clear.
6. Mode switch: SCAN->DIRECT at scan_idx=2 with sel_valid=0 -> dec_out holds 6'b000100; then sel=5 -> dec_out=6'b100000.
